// File: rtl/pcie_upsize_fifo.sv
// Single-clock 16->128 (IN->OUT) packing FIFO with flush, almost flags and overflow/underflow pulses.
// Define PCIE_UPSIZE_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle read latency.
module pcie_upsize_fifo #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned OUT_WIDTH   = 128,
    parameter int unsigned DEPTH_WIDTH = 9,
    localparam int unsigned RATIO      = OUT_WIDTH / IN_WIDTH,
    localparam int unsigned RW         = $clog2(RATIO),
    localparam int unsigned WL_W       = DEPTH_WIDTH + RW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [IN_WIDTH-1:0]    wr_data,
    input  logic                   wr_flush,
    output logic                   wr_full,
    output logic                   wr_overflow,
    input  logic [WL_W-1:0]        almost_full_thr,
    output logic                   almost_full,
    output logic [WL_W-1:0]        wr_water_level,
    input  logic                   rd_en,
    output logic [OUT_WIDTH-1:0]   rd_data,
    output logic                   rd_empty,
    output logic                   rd_underflow,
    input  logic [DEPTH_WIDTH:0]   almost_empty_thr,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level
);
    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [RW-1:0] LastLane = RW'(RATIO - 1);
    localparam logic [DEPTH_WIDTH:0] DepthCnt = (DEPTH_WIDTH + 1)'(DEPTH);

    logic [OUT_WIDTH-1:0]   mem [DEPTH];
    logic [IN_WIDTH-1:0]    pack_q [RATIO-1];
    logic [RW-1:0]          pack_cnt_q;
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [DEPTH_WIDTH:0]   count_q;
    logic [OUT_WIDTH-1:0]   commit_word, rd_data_q;
    logic                   overflow_q, underflow_q;
    logic                   at_cap, wr_accept, pack_done, pending, flush_ok, flush_drop;
    logic                   push, pop;

    always_comb begin
        at_cap     = count_q == DepthCnt;
        wr_full    = at_cap && (pack_cnt_q == LastLane);
        wr_accept  = wr_en && !wr_full;
        pack_done  = wr_accept && (pack_cnt_q == LastLane);
        pending    = (pack_cnt_q != '0) || wr_en;
        flush_ok   = wr_flush && pending && !at_cap;
        flush_drop = wr_flush && pending && at_cap;
        push       = pack_done || flush_ok;
        rd_empty   = count_q == '0;
        pop        = rd_en && !rd_empty;
        rd_ptr_nxt = rd_ptr_q + DEPTH_WIDTH'(pop);

        // Lanes not yet written are zero, which is what a partial flush needs.
        commit_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (RW'(i) < pack_cnt_q) begin
                commit_word[i*IN_WIDTH +: IN_WIDTH] = pack_q[i];
            end else if (wr_accept && (RW'(i) == pack_cnt_q)) begin
                commit_word[i*IN_WIDTH +: IN_WIDTH] = wr_data;
            end
        end
        if (pack_done) begin
            commit_word[OUT_WIDTH-1 -: IN_WIDTH] = wr_data;
        end

        wr_water_level = {count_q, pack_cnt_q};
        almost_full    = wr_water_level >= almost_full_thr;
        rd_water_level = count_q;
        almost_empty   = count_q <= almost_empty_thr;
        wr_overflow    = overflow_q;
        rd_underflow   = underflow_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= commit_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < RATIO - 1; i++) begin
                pack_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RATIO - 1; i++) begin
                if (wr_accept && !push && (pack_cnt_q == RW'(i))) begin
                    pack_q[i] <= wr_data;
                end
            end
            if (push) begin
                pack_cnt_q <= '0;
                wr_ptr_q   <= wr_ptr_q + 1'b1;
            end else if (wr_accept) begin
                pack_cnt_q <= pack_cnt_q + 1'b1;
            end
            rd_ptr_q    <= rd_ptr_nxt;
            count_q     <= count_q + (DEPTH_WIDTH + 1)'(push) - (DEPTH_WIDTH + 1)'(pop);
            overflow_q  <= (wr_en && wr_full) || flush_drop;
            underflow_q <= rd_en && rd_empty;
        end
    end

`ifdef PCIE_UPSIZE_FIFO_FWFT_EN
    // Head register tracks RAM[rd_ptr]; bypass covers a word written into the head slot this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (push && (wr_ptr_q == rd_ptr_nxt)) begin
            rd_data_q <= commit_word;
        end else begin
            rd_data_q <= mem[rd_ptr_nxt];
        end
    end

    assign rd_data = rd_empty ? '0 : rd_data_q;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (pop) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_pcie_upsize_fifo.sv
// Self-checking bench for pcie_upsize_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pcie_upsize_fifo;
    localparam int IW = 16;
    localparam int OW = 128;
    localparam int DW = 9;
    localparam int RATIO = OW / IW;
    localparam int DEPTH = 1 << DW;
    localparam int WLW = DW + $clog2(RATIO) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [IW-1:0]   wr_data = '0;
    logic            wr_flush = 1'b0;
    logic            wr_full, wr_overflow, almost_full;
    logic [WLW-1:0]  almost_full_thr = '0;
    logic [WLW-1:0]  wr_water_level;
    logic            rd_en = 1'b0;
    logic [OW-1:0]   rd_data;
    logic            rd_empty, rd_underflow, almost_empty;
    logic [DW:0]     almost_empty_thr = '0;
    logic [DW:0]     rd_water_level;

    pcie_upsize_fifo dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .wr_flush         (wr_flush),
        .wr_full          (wr_full),
        .wr_overflow      (wr_overflow),
        .almost_full_thr  (almost_full_thr),
        .almost_full      (almost_full),
        .wr_water_level   (wr_water_level),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .rd_empty         (rd_empty),
        .rd_underflow     (rd_underflow),
        .almost_empty_thr (almost_empty_thr),
        .almost_empty     (almost_empty),
        .rd_water_level   (rd_water_level)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: a queue of committed OUT words plus a queue of pending IN words.
    logic [OW-1:0] mq[$];
    logic [IW-1:0] pk[$];
    logic [OW-1:0] m_rd = '0;
    logic          m_ovf = 1'b0;
    logic          m_und = 1'b0;

    typedef struct {
        logic          we;
        logic [IW-1:0] wd;
        logic          fl;
        logic          re;
        int            wl;
        int            rl;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_update(input logic r, input logic we, input logic [IW-1:0] wd,
                                input logic fl, input logic re);
        int cnt;
        logic full;
        logic [OW-1:0] w;
        if (!r) begin
            mq.delete();
            pk.delete();
            m_rd = '0;
            m_ovf = 1'b0;
            m_und = 1'b0;
            return;
        end
        cnt  = mq.size();
        full = (cnt == DEPTH) && (pk.size() == RATIO - 1);
        m_ovf = (we && full) || (fl && (pk.size() != 0 || we) && cnt == DEPTH);
        m_und = re && (cnt == 0);
        if (re && cnt > 0) m_rd = mq.pop_front();
        if (we && !full) pk.push_back(wd);
        if (pk.size() == RATIO || (fl && pk.size() > 0 && cnt < DEPTH)) begin
            w = '0;
            foreach (pk[i]) w[i*IW +: IW] = pk[i];
            mq.push_back(w);
            pk.delete();
        end
    endtask

    task automatic compare_all();
        int wl;
        logic [OW-1:0] exp_rd;
        wl = mq.size() * RATIO + pk.size();
`ifdef PCIE_UPSIZE_FIFO_FWFT_EN
        exp_rd = (mq.size() > 0) ? mq[0] : '0;
`else
        exp_rd = m_rd;
`endif
        chk("rd_data", rd_data, exp_rd);
        chk("rd_empty", OW'(rd_empty), OW'(mq.size() == 0));
        chk("wr_full", OW'(wr_full), OW'(mq.size() == DEPTH && pk.size() == RATIO - 1));
        chk("wr_overflow", OW'(wr_overflow), OW'(m_ovf));
        chk("rd_underflow", OW'(rd_underflow), OW'(m_und));
        chk("wr_water_level", OW'(wr_water_level), OW'(wl));
        chk("rd_water_level", OW'(rd_water_level), OW'(mq.size()));
        chk("almost_full", OW'(almost_full), OW'(wl >= int'(almost_full_thr)));
        chk("almost_empty", OW'(almost_empty), OW'(mq.size() <= int'(almost_empty_thr)));
    endtask

    task automatic step(input logic r, input logic we, input logic [IW-1:0] wd,
                        input logic fl, input logic re);
        rst_n = r;
        wr_en = we;
        wr_data = wd;
        wr_flush = fl;
        rd_en = re;
        @(posedge clk);
        model_update(r, we, wd, fl, re);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [OW-1:0] rd_after_first;
        logic [OW-1:0] exp_first, exp_second;

        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, IW'(i + 1), 1'b0, 1'b0, i + 1, (i == 7) ? 1 : 0};
        tbl[8]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 9, 1};
        tbl[9]  = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 10, 1};
        tbl[10] = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 11, 1};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16, 2};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8, 1};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 0};

        // Reset state, including almost_full with a zero threshold.
        almost_full_thr = '0;
        almost_empty_thr = '0;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("reset almost_full thr0", OW'(almost_full), OW'(1));
        chk("reset rd_empty", OW'(rd_empty), OW'(1));
        almost_full_thr = WLW'(100);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("reset almost_full thr100", OW'(almost_full), OW'(0));

        // Pack and flush vectors.
        rd_after_first = '0;
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].we, tbl[i].wd, tbl[i].fl, tbl[i].re);
            chk($sformatf("vec%0d wl", i), OW'(wr_water_level), OW'(tbl[i].wl));
            chk($sformatf("vec%0d rl", i), OW'(rd_water_level), OW'(tbl[i].rl));
            if (i == 12) rd_after_first = rd_data;
        end
`ifdef PCIE_UPSIZE_FIFO_FWFT_EN
        exp_first  = 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA;
        exp_second = '0;
`else
        exp_first  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        exp_second = 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA;
`endif
        chk("pack word", rd_after_first, exp_first);
        chk("flush word", rd_data, exp_second);

        // Flush with pack empty is a no-op; flush with a same-cycle final write is a single push.
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flush noop rl", OW'(rd_water_level), OW'(0));
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, IW'(16'h100 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1FF, 1'b1, 1'b0);
        chk("flush+last rl", OW'(rd_water_level), OW'(1));
        chk("flush+last wl", OW'(wr_water_level), OW'(8));

        // Simultaneous pop and completing write at count 1.
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, IW'(16'h200 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h20F, 1'b0, 1'b1);
        chk("simul rd_empty", OW'(rd_empty), OW'(0));
        chk("simul rl", OW'(rd_water_level), OW'(1));
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Underflow: rd_en on empty must not move the read pointer.
        do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("underflow pulse", OW'(rd_underflow), OW'(1));
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("underflow clear", OW'(rd_underflow), OW'(0));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, IW'(16'h300 + i), 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Fill to capacity with thresholds, then overflow, dropped flush, one pop and refill.
        almost_full_thr = WLW'(4064);
        almost_empty_thr = (DW + 1)'(4);
        do_reset();
        for (int n = 1; n <= DEPTH * RATIO + RATIO - 1; n++) begin
            step(1'b1, 1'b1, IW'(n), 1'b0, 1'b0);
            if (n == 32)   chk("almost_empty at 4", OW'(almost_empty), OW'(1));
            if (n == 40)   chk("almost_empty at 5", OW'(almost_empty), OW'(0));
            if (n == 4063) chk("almost_full at 4063", OW'(almost_full), OW'(0));
            if (n == 4064) chk("almost_full at 4064", OW'(almost_full), OW'(1));
            if (n == 4095) chk("wr_full at 4095", OW'(wr_full), OW'(0));
            if (n == 4096) chk("wl at 4096", OW'(wr_water_level), OW'(4096));
        end
        chk("wr_full at cap", OW'(wr_full), OW'(1));
        step(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("overflow pulse", OW'(wr_overflow), OW'(1));
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flush drop pulse", OW'(wr_overflow), OW'(1));
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("full after pop", OW'(wr_full), OW'(0));
        for (int i = 0; i < RATIO; i++) step(1'b1, 1'b1, IW'(16'h5000 + i), 1'b0, 1'b0);
        chk("refill wl", OW'(wr_water_level), OW'(DEPTH * RATIO + RATIO - 1));
        chk("refill full", OW'(wr_full), OW'(1));

        // Reset mid-traffic with count=100, pack_cnt=3.
        do_reset();
        for (int i = 0; i < 803; i++) step(1'b1, 1'b1, IW'(i), 1'b0, 1'b0);
        chk("pre-reset rl", OW'(rd_water_level), OW'(100));
        step(1'b0, 1'b1, 16'h7777, 1'b0, 1'b1);
        chk("mid reset empty", OW'(rd_empty), OW'(1));
        chk("mid reset wl", OW'(wr_water_level), OW'(0));
        chk("mid reset rl", OW'(rd_water_level), OW'(0));
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic with alternating fill/drain bias and live threshold changes.
        for (int c = 0; c < 4000; c++) begin
            logic we, fl, re;
            if (c % 100 == 0) begin
                almost_full_thr = WLW'($urandom_range(0, DEPTH * RATIO + RATIO));
                almost_empty_thr = (DW + 1)'($urandom_range(0, DEPTH));
            end
            if ((c / 500) % 2 == 0) begin
                we = ($urandom % 8) != 0;
                re = ($urandom % 4) == 0;
            end else begin
                we = ($urandom % 4) == 0;
                re = ($urandom % 8) != 0;
            end
            fl = ($urandom % 12) == 0;
            step(1'b1, we, IW'($urandom), fl, re);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
